// File: rtl/hdmi_period_scheduler.sv
// HDMI period scheduler: tracks control, video and data-island periods per pixel and emits mode/ctl/slot index.
// Latency: outputs for input column cx are registered and appear one clk_pix later.
// Backpressure: pkt_ready pulses once per 32-cycle slot; no stall path. HDMI_DATA_ISLAND_EN enables islands (DVI otherwise).
module hdmi_period_scheduler #(
    parameter int FRAME_WIDTH    = 800,
    parameter int FRAME_HEIGHT   = 525,
    parameter int SCREEN_START_X = 160,
    parameter int SCREEN_START_Y = 45,
    parameter int MAX_PKTS       = 18
) (
    input  logic       clk_pix,
    input  logic       rst_in,
    input  logic [9:0] cx,
    input  logic [9:0] cy,
    input  logic       pkt_valid,
    output logic       pkt_ready,
    output logic [2:0] mode,
    output logic [3:0] ctl,
    output logic [4:0] island_cnt
);

    typedef enum logic [2:0] {
        CTRL, VID_PRE, VID_GB, VID
`ifdef HDMI_DATA_ISLAND_EN
        , ISL_PRE, ISL_LGB, ISL_DATA, ISL_TGB
`endif
    } state_t;

    localparam logic [2:0]  MODE_CTRL = 3'd0;
    localparam logic [2:0]  MODE_VID  = 3'd1;
    localparam logic [2:0]  MODE_VGB  = 3'd2;
    localparam logic [10:0] FW        = 11'(FRAME_WIDTH);
    localparam logic [10:0] FH        = 11'(FRAME_HEIGHT);
    localparam logic [9:0]  VPRE_X    = 10'(SCREEN_START_X - 10);
    localparam logic [9:0]  VGB_X     = 10'(SCREEN_START_X - 2);
    localparam logic [9:0]  VID_X     = 10'(SCREEN_START_X);
    localparam logic [9:0]  VID_Y     = 10'(SCREEN_START_Y);

    state_t     state, nxt_state;
    logic [3:0] ctrl_cnt;
    logic       cx_ok, video_line;

    assign cx_ok      = {1'b0, cx} < FW;
    assign video_line = (cy >= VID_Y) && ({1'b0, cy} < FH);

`ifdef HDMI_DATA_ISLAND_EN
    localparam logic [2:0]  MODE_IGB  = 3'd3;
    localparam logic [2:0]  MODE_IDAT = 3'd4;
    // Islands must finish before this column so 12 control cycles precede the video preamble.
    localparam logic [10:0] ISL_LIMIT = 11'(SCREEN_START_X - 22);
    localparam logic [4:0]  PKT_MAX   = 5'(MAX_PKTS);

    logic [2:0]  phase, nxt_phase;
    logic [4:0]  pkt_cnt, nxt_icnt;
    logic        isl_start, slot_start;
    logic [10:0] cx_ext;

    assign cx_ext = {1'b0, cx};
`else
    logic unused_dvi;
    assign unused_dvi = pkt_valid ^ (|ctrl_cnt) ^ (state == VID) ^ (MAX_PKTS > 0);
`endif

    always_comb begin
        nxt_state = CTRL;
`ifdef HDMI_DATA_ISLAND_EN
        nxt_phase  = '0;
        nxt_icnt   = '0;
        isl_start  = 1'b0;
        slot_start = 1'b0;
`endif
        if (video_line && cx_ok && cx >= VPRE_X) begin
            if (cx >= VID_X)
                nxt_state = VID;
            else if (cx >= VGB_X)
                nxt_state = VID_GB;
            else
                nxt_state = VID_PRE;
        end
`ifdef HDMI_DATA_ISLAND_EN
        else if (cx_ok && cx != 10'd0) begin
            case (state)
                ISL_PRE: begin
                    nxt_state = (phase == 3'd7) ? ISL_LGB : ISL_PRE;
                    nxt_phase = (phase == 3'd7) ? 3'd0 : phase + 3'd1;
                end
                ISL_LGB: begin
                    if (phase == 3'd1) begin
                        nxt_state  = ISL_DATA;
                        slot_start = 1'b1;
                    end else begin
                        nxt_state = ISL_LGB;
                        nxt_phase = phase + 3'd1;
                    end
                end
                ISL_DATA: begin
                    if (island_cnt != 5'd31) begin
                        nxt_state = ISL_DATA;
                        nxt_icnt  = island_cnt + 5'd1;
                    end else if (pkt_valid && pkt_cnt < PKT_MAX && cx_ext + 11'd34 <= ISL_LIMIT) begin
                        nxt_state  = ISL_DATA;
                        slot_start = 1'b1;
                    end else begin
                        nxt_state = ISL_TGB;
                    end
                end
                ISL_TGB: begin
                    nxt_state = (phase == 3'd1) ? CTRL : ISL_TGB;
                    nxt_phase = (phase == 3'd1) ? 3'd0 : phase + 3'd1;
                end
                default: begin
                    if (pkt_valid && ctrl_cnt >= 4'd12 && cx_ext + 11'd44 <= ISL_LIMIT) begin
                        nxt_state = ISL_PRE;
                        isl_start = 1'b1;
                    end
                end
            endcase
        end
`endif
    end

    always_ff @(posedge clk_pix) begin
        if (!rst_in) begin
            state      <= CTRL;
            ctrl_cnt   <= '0;
            mode       <= MODE_CTRL;
            ctl        <= '0;
            pkt_ready  <= 1'b0;
            island_cnt <= '0;
`ifdef HDMI_DATA_ISLAND_EN
            phase      <= '0;
            pkt_cnt    <= '0;
`endif
        end else begin
            state    <= nxt_state;
            ctrl_cnt <= (nxt_state != CTRL) ? 4'd0 :
                        (ctrl_cnt == 4'd15) ? 4'd15 : ctrl_cnt + 4'd1;
            mode     <= MODE_CTRL;
            ctl      <= 4'b0000;
            case (nxt_state)
                VID_PRE:  ctl  <= 4'b0001;
                VID_GB:   mode <= MODE_VGB;
                VID:      mode <= MODE_VID;
`ifdef HDMI_DATA_ISLAND_EN
                ISL_PRE:  ctl  <= 4'b0101;
                ISL_LGB:  mode <= MODE_IGB;
                ISL_TGB:  mode <= MODE_IGB;
                ISL_DATA: mode <= MODE_IDAT;
`endif
                default: ;
            endcase
`ifdef HDMI_DATA_ISLAND_EN
            phase      <= nxt_phase;
            island_cnt <= nxt_icnt;
            pkt_ready  <= slot_start;
            if (isl_start)
                pkt_cnt <= '0;
            else if (slot_start)
                pkt_cnt <= pkt_cnt + 5'd1;
`else
            pkt_ready  <= 1'b0;
            island_cnt <= '0;
`endif
        end
    end

endmodule

// File: tb/tb_hdmi_period_scheduler.sv
// Directed bench for hdmi_period_scheduler: whole-line sweeps checked cycle by cycle against hand-placed period windows.
module tb_hdmi_period_scheduler;

    logic       clk_pix = 1'b0;
    logic       rst_in;
    logic [9:0] cx, cy;
    logic       pkt_valid;
    logic       pkt_ready;
    logic [2:0] mode;
    logic [3:0] ctl;
    logic [4:0] island_cnt;

    int n_checks = 0;
    int n_errors = 0;

`ifdef HDMI_DATA_ISLAND_EN
    localparam bit ISL_EN = 1'b1;
`else
    localparam bit ISL_EN = 1'b0;
`endif

    always #5 clk_pix = ~clk_pix;

    hdmi_period_scheduler dut (
        .clk_pix    (clk_pix),
        .rst_in     (rst_in),
        .cx         (cx),
        .cy         (cy),
        .pkt_valid  (pkt_valid),
        .pkt_ready  (pkt_ready),
        .mode       (mode),
        .ctl        (ctl),
        .island_cnt (island_cnt)
    );

    task automatic check(input string tag, input logic [12:0] got, input logic [12:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got mode=%0d ctl=%b rdy=%b icnt=%0d, expected mode=%0d ctl=%b rdy=%b icnt=%0d",
                     tag, got[12:10], got[9:6], got[5], got[4:0], exp[12:10], exp[9:6], exp[5], exp[4:0]);
        end
    endtask

    // Expected {mode, ctl, pkt_ready, island_cnt} for column c; s < 0 means no island on the line.
    function automatic logic [12:0] exp_out(input int c, input bit vid_line, input int s, input int nslots);
        logic [2:0] m;
        logic [3:0] k;
        logic       r;
        logic [4:0] ic;
        int         dstart, dend;
        m = 3'd0; k = 4'd0; r = 1'b0; ic = 5'd0;
        dstart = s + 10;
        dend   = dstart + 32 * nslots;
        if (vid_line && c >= 150) begin
            if (c >= 160)      m = 3'd1;
            else if (c >= 158) m = 3'd2;
            else               k = 4'b0001;
        end else if (s >= 0) begin
            if (c >= s && c < s + 8)            k = 4'b0101;
            else if (c >= s + 8 && c < dstart)  m = 3'd3;
            else if (c >= dstart && c < dend) begin
                m  = 3'd4;
                ic = 5'((c - dstart) % 32);
                r  = (ic == 5'd0);
            end
            else if (c >= dend && c < dend + 2) m = 3'd3;
        end
        return {m, k, r, ic};
    endfunction

    function automatic logic [12:0] obs();
        return {mode, ctl, pkt_ready, island_cnt};
    endfunction

    function automatic int isl(input int s);
        return ISL_EN ? s : -1;
    endfunction

    task automatic drive(input int c);
        cx = 10'(c);
        @(posedge clk_pix);
        #1;
    endtask

    task automatic run_line(input int line_id, input int cy_v, input bit vid_line,
                            input int pv_from, input int s, input int nslots);
        cy = 10'(cy_v);
        for (int c = 0; c < 800; c++) begin
            pkt_valid = (pv_from >= 0) && (c >= pv_from);
            drive(c);
            check($sformatf("line%0d cx%0d", line_id, c), obs(), exp_out(c, vid_line, s, nslots));
        end
    endtask

    initial begin
        rst_in = 1'b0; cx = '0; cy = '0; pkt_valid = 1'b0;
        drive(0);
        drive(0);
        check("reset", obs(), 13'd0);
        rst_in = 1'b1;

        run_line(1, 100, 1'b1, -1, -1, 0);        // plain video line
        run_line(2, 100, 1'b1, 0, isl(12), 3);    // three-packet island
        run_line(3, 100, 1'b1, 95, -1, 0);        // request too late for this line
        run_line(4, 100, 1'b1, 0, isl(12), 3);    // deferred island on next line
        run_line(5, 10, 1'b0, 0, isl(12), 3);     // blank line with island
        run_line(6, 100, 1'b1, -1, -1, 0);

        // Reset in the middle of the first packet slot.
        cy = 10'd100;
        pkt_valid = 1'b1;
        for (int c = 0; c < 40; c++) begin
            drive(c);
            check($sformatf("line7 cx%0d", c), obs(), exp_out(c, 1'b1, isl(12), 3));
        end
        rst_in = 1'b0;
        drive(40);
        check("reset mid-island", obs(), 13'd0);
        rst_in = 1'b1;
        for (int c = 41; c < 800; c++) begin
            drive(c);
            check($sformatf("line7 cx%0d", c), obs(), exp_out(c, 1'b1, isl(53), 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/hdmi_period_scheduler.md
HDMI_PERIOD_SCHEDULER -- requirements
Module: hdmi_period_scheduler

Interface
REQ-001 SHALL have parameter FRAME_WIDTH, default 800: total pixels per line.
REQ-002 SHALL have parameter FRAME_HEIGHT, default 525: total lines per frame.
REQ-003 SHALL have parameter SCREEN_START_X, default 160: first active column.
REQ-004 SHALL have parameter SCREEN_START_Y, default 45: first active line.
REQ-005 SHALL have parameter MAX_PKTS, default 18: maximum packets per data island.
REQ-006 SHALL have port clk_pix, input, 1: pixel clock; the only clock.
REQ-007 SHALL have port rst_in, input, 1: synchronous, active-low reset.
REQ-008 SHALL have port cx, input, 10: current column, 0..FRAME_WIDTH-1.
REQ-009 SHALL have port cy, input, 10: current line, 0..FRAME_HEIGHT-1.
REQ-010 SHALL have port pkt_valid, input, 1: packet encoder has a packet pending.
REQ-011 SHALL have port pkt_ready, output, 1: one-cycle pulse marking the first cycle of a 32-cycle packet slot; the packet is consumed.
REQ-012 SHALL have port mode, output, 3: period code. 0 = control, 1 = video data, 2 = video guard, 3 = island guard, 4 = island data.
REQ-013 SHALL have port ctl, output, 4: CTL3..CTL0 preamble bits.
REQ-014 SHALL have port island_cnt, output, 5: word index 0..31 within the current packet slot.

Function
REQ-015 SHALL register all outputs; the outputs for input column cx appear one clk_pix later.
REQ-016 SHALL provide states CTRL, VID_PRE, VID_GB, VID, ISL_PRE, ISL_LGB, ISL_DATA and ISL_TGB.
REQ-017 SHALL run the video sequence only when cy >= SCREEN_START_Y:
- VID_PRE for cx in SCREEN_START_X-10..-3, with mode 0 and ctl 4'b0001.
- VID_GB for cx in SCREEN_START_X-2..-1, with mode 2.
- VID for cx >= SCREEN_START_X, with mode 1.
REQ-018 SHALL return to CTRL when cx wraps from FRAME_WIDTH-1 to 0.
REQ-019 SHALL maintain ctrl_cnt, the number of consecutive CTRL cycles, saturating at 15; ctrl_cnt SHALL clear on leaving CTRL.
REQ-020 SHALL enter ISL_PRE from CTRL only when all of the following hold: pkt_valid=1, ctrl_cnt >= 12, and cx + 44 <= D, where D = SCREEN_START_X - 22.
REQ-021 SHALL run the island sequence as follows:
- ISL_PRE for 8 cycles, with mode 0 and ctl 4'b0101.
- ISL_LGB for 2 cycles, with mode 3.
- ISL_DATA in 32-cycle slots, with mode 4 and island_cnt counting 0..31.
- ISL_TGB for 2 cycles, with mode 3.
- Then CTRL.
REQ-022 SHALL pulse pkt_ready when island_cnt = 0 in every slot.
REQ-023 SHALL start another slot at the end of a slot only when all of the following hold: pkt_valid=1, pkt_cnt < MAX_PKTS, and cx + 34 <= D. Otherwise the block SHALL go to ISL_TGB.
REQ-024 SHALL treat pkt_valid deassertion during a slot as having no effect on that slot.
REQ-025 SHALL give video priority over islands: an island SHALL never start or extend past D, so at least 12 control cycles always precede VID_PRE.
REQ-026 SHALL keep ctl = 0 in all states except VID_PRE and ISL_PRE.
REQ-027 SHALL keep island_cnt = 0 outside ISL_DATA.
REQ-028 SHALL reset pkt_cnt to 0 on island entry.

Reset
REQ-029 SHALL, when rst_in=0 at a clk_pix edge, set: state CTRL, mode 0, ctl 0, pkt_ready 0, island_cnt 0, ctrl_cnt 0, pkt_cnt 0.
REQ-030 SHALL abort any in-progress island on reset; an aborted packet SHALL NOT be re-acknowledged.
REQ-031 SHALL resume scheduling from the first cx sampled after rst_in returns to 1.

Configuration
REQ-032 SHALL use macro HDMI_DATA_ISLAND_EN to select the operating mode:
- Defined: data islands are scheduled as specified above.
- Undefined: DVI mode. ISL_* states are removed, pkt_ready is tied to 0, mode never takes values 3 or 4, and the video sequence is unchanged.

Verification
REQ-033 Video line: cy=100, cx sweep 0..799, pkt_valid=0 -> outputs per cx:
- cx 150..157: mode 0, ctl 0001.
- cx 158..159: mode 2.
- cx 160..799: mode 1.
- All other cx: mode 0, ctl 0.
REQ-034 Three-packet island: cy=100, pkt_valid=1 from cx=0 -> outputs per cx:
- ISL_PRE at cx 12..19.
- ISL_LGB at cx 20..21.
- pkt_ready at cx 22, 54 and 86.
- ISL_DATA through cx 117.
- ISL_TGB at cx 118..119.
- CTRL from cx 120 to 149.
REQ-035 Late request: pkt_valid rises at cx=95 -> no island on this line, pkt_ready stays 0; the island starts at cx=12 of the next line.
REQ-036 Blank line: cy=10 -> no mode 1/2 and no ctl 0001 across the whole line; the island behaves as in REQ-034.
REQ-037 Reset mid-island: rst_in=0 at cx=40 -> next cycle mode 0, pkt_ready 0, island_cnt 0; the next island is not before ctrl_cnt reaches 12.
REQ-038 HDMI_DATA_ISLAND_EN undefined: run REQ-034 stimulus -> pkt_ready never 1, mode never 3 or 4, video timing identical to REQ-033.
